mod_n_counter: RTL and testbench

//   Free-running modulo-N counter: out steps 0,1,..,N-1, then wraps to 0 on every clk edge.

---
 rtl/mod_n_counter_pkg.sv | 22 ++
 rtl/mod_n_next_state.sv | 46 ++++
 rtl/mod_n_counter.sv | 72 +++++++
 tb/tb_mod_n_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_n_counter_pkg.sv
// mod_n_counter_pkg
//   Shared constants and elaboration helpers for the modulo-N counter.
//   N_DEF / WIDTH_DEF : default modulus and output width.
//   params_ok()       : legality check for an (N, WIDTH) pair.
//   last_of()         : terminal value N-1 used by the wrap compare.
package mod_n_counter_pkg;

  localparam int N_DEF     = 10;
  localparam int WIDTH_DEF = 4;

  // N must be at least 2 and representable in WIDTH bits, i.e. N <= 2**WIDTH.
  // $clog2(N) <= WIDTH expresses the same bound without a 2**WIDTH overflow
  // for wide counters.
  function automatic bit params_ok(input int n, input int width);
    return (n >= 2) && (width >= 1) && ($clog2(n) <= width);
  endfunction

  function automatic int last_of(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/mod_n_next_state.sv
// mod_n_next_state
//   Pure combinational next-count and terminal-count decode for mod_n_counter.
//   Ports:
//     cur   in  WIDTH  current registered count
//     up_dn in  1      1 = count up, 0 = count down
//     nxt   out WIDTH  value to load on the next clock edge (before reset)
//     tc    out 1      terminal count for the current direction
module mod_n_next_state
  import mod_n_counter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up_dn,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(last_of(N));
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // "cur > LAST" stands in for "cur >= N" so the compare stays WIDTH bits
  // wide even when N == 2**WIDTH (N itself would not fit).
  always_comb begin
    nxt = '0;
    tc  = 1'b0;
    if (up_dn) begin
      tc = (cur == LAST);
      if (cur >= LAST) begin
        // Covers the normal wrap and any out-of-range state.
        nxt = '0;
      end else begin
        nxt = cur + ONE;
      end
    end else begin
      tc = (cur == '0);
      if ((cur == '0) || (cur > LAST)) begin
        nxt = LAST;
      end else begin
        nxt = cur - ONE;
      end
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// mod_n_counter
//   Free-running modulo-N counter with terminal-count flag, for tick
//   generation and cascaded timebases.
//   Optional feature macro: MOD_N_COUNTER_UPDOWN_EN adds the up_dn input
//   (1 = up, 0 = down). Without it the counter only counts up.
//   Ports:
//     clk   in  1      rising-edge clock
//     rstn  in  1      synchronous reset, active HIGH (1 = reset)
//     up_dn in  1      direction, present only with MOD_N_COUNTER_UPDOWN_EN
//     out   out WIDTH  registered count value
//     tc    out 1      terminal count, decoded from out (and direction)
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef MOD_N_COUNTER_UPDOWN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  generate
    if (!params_ok(N, WIDTH)) begin : g_bad_params
      $error("mod_n_counter: illegal parameters N=%0d WIDTH=%0d (need 2 <= N <= 2**WIDTH)",
             N, WIDTH);
    end
  endgenerate

  logic             dir;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] nxt_val;
  logic             tc_val;

`ifdef MOD_N_COUNTER_UPDOWN_EN
  assign dir = up_dn;
`else
  assign dir = 1'b1;
`endif

  mod_n_next_state #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_next (
    .cur   (out_q),
    .up_dn (dir),
    .nxt   (nxt_val),
    .tc    (tc_val)
  );

  always_comb begin
    out_d = nxt_val;
  end

  // Reset takes priority over both increment and wrap on the same edge.
  always_ff @(posedge clk) begin
    if (rstn) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_val;

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [3:0] out_a;
  logic [3:0] out_b;
  logic       tc_a;
  logic       tc_b;
`ifdef MOD_N_COUNTER_UPDOWN_EN
  logic       up_dn_a = 1'b1;
  logic       up_dn_b = 1'b1;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mod_n_counter #(.N(10), .WIDTH(4)) dut_a (
    .clk   (clk),
    .rstn  (rst_a),
`ifdef MOD_N_COUNTER_UPDOWN_EN
    .up_dn (up_dn_a),
`endif
    .out   (out_a),
    .tc    (tc_a)
  );

  mod_n_counter #(.N(16), .WIDTH(4)) dut_b (
    .clk   (clk),
    .rstn  (rst_b),
`ifdef MOD_N_COUNTER_UPDOWN_EN
    .up_dn (up_dn_b),
`endif
    .out   (out_b),
    .tc    (tc_b)
  );

  // Advance one rising edge, then sample on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (out_a !== 4'h0) $display("FAIL reset_out: got %0h expected 0", out_a);
    else pass_cnt++;
    total_cnt++;
    if (tc_a !== 1'b0) $display("FAIL reset_tc: got %0b expected 0", tc_a);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (out_a !== 4'h0) $display("FAIL reset_hold[%0d]: got %0h expected 0", i, out_a);
      else pass_cnt++;
    end
  endtask

  task automatic test_count_wrap();
    logic [3:0] exp_out;
    logic       exp_tc;
    rst_a = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_out = 4'(i % 10);
      exp_tc  = (exp_out == 4'd9);
      total_cnt++;
      if (out_a !== exp_out) $display("FAIL count_out[%0d]: got %0h expected %0h", i, out_a, exp_out);
      else pass_cnt++;
      total_cnt++;
      if (tc_a !== exp_tc) $display("FAIL count_tc[%0d]: got %0b expected %0b", i, tc_a, exp_tc);
      else pass_cnt++;
    end
  endtask

  // rstn pulses that start and end between rising edges must be ignored.
  task automatic test_reset_glitch();
    #2 rst_a = 1'b1;
    #1 rst_a = 1'b0;
    tick();
    total_cnt++;
    if (out_a !== 4'h1) $display("FAIL glitch_pre: got %0h expected 1", out_a);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_a = 1'b1;
    #1 rst_a = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (out_a !== 4'h2) $display("FAIL glitch_post: got %0h expected 2", out_a);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_out;
    for (int i = 0; i < 4; i++) tick();
    total_cnt++;
    if (out_a !== 4'h6) $display("FAIL mid_pre: got %0h expected 6", out_a);
    else pass_cnt++;
    rst_a = 1'b1;
    tick();
    total_cnt++;
    if (out_a !== 4'h0) $display("FAIL mid_reset: got %0h expected 0", out_a);
    else pass_cnt++;
    rst_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_out = 4'(i);
      total_cnt++;
      if (out_a !== exp_out) $display("FAIL mid_resume[%0d]: got %0h expected %0h", i, out_a, exp_out);
      else pass_cnt++;
    end
  endtask

  task automatic test_pow2();
    logic [3:0] exp_out;
    logic       exp_tc;
    rst_b = 1'b1;
    tick();
    total_cnt++;
    if (out_b !== 4'h0) $display("FAIL pow2_reset: got %0h expected 0", out_b);
    else pass_cnt++;
    rst_b = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp_out = 4'(i % 16);
      exp_tc  = (exp_out == 4'hF);
      total_cnt++;
      if (out_b !== exp_out) $display("FAIL pow2_out[%0d]: got %0h expected %0h", i, out_b, exp_out);
      else pass_cnt++;
      total_cnt++;
      if (tc_b !== exp_tc) $display("FAIL pow2_tc[%0d]: got %0b expected %0b", i, tc_b, exp_tc);
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal_state();
    force dut_a.out_q = 4'hC;
    #1 release dut_a.out_q;
    #1;
    total_cnt++;
    if (out_a !== 4'hC) $display("FAIL illegal_load: got %0h expected c", out_a);
    else pass_cnt++;
    total_cnt++;
    if (tc_a !== 1'b0) $display("FAIL illegal_tc: got %0b expected 0", tc_a);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_a !== 4'h0) $display("FAIL illegal_recover: got %0h expected 0", out_a);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_a !== 4'h1) $display("FAIL illegal_next: got %0h expected 1", out_a);
    else pass_cnt++;
  endtask

`ifdef MOD_N_COUNTER_UPDOWN_EN
  task automatic test_updown();
    logic [3:0] exp_out;
    logic       exp_tc;
    up_dn_a = 1'b0;
    rst_a   = 1'b1;
    tick();
    total_cnt++;
    if (out_a !== 4'h0) $display("FAIL ud_reset: got %0h expected 0", out_a);
    else pass_cnt++;
    total_cnt++;
    if (tc_a !== 1'b1) $display("FAIL ud_reset_tc: got %0b expected 1", tc_a);
    else pass_cnt++;
    rst_a = 1'b0;
    // 0 -> 9,8,...,0,9
    for (int i = 0; i <= 10; i++) begin
      tick();
      exp_out = (i == 10) ? 4'd9 : 4'(9 - i);
      exp_tc  = (exp_out == 4'd0);
      total_cnt++;
      if (out_a !== exp_out) $display("FAIL ud_down[%0d]: got %0h expected %0h", i, out_a, exp_out);
      else pass_cnt++;
      total_cnt++;
      if (tc_a !== exp_tc) $display("FAIL ud_down_tc[%0d]: got %0b expected %0b", i, tc_a, exp_tc);
      else pass_cnt++;
    end
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (out_a !== 4'h4) $display("FAIL ud_at4: got %0h expected 4", out_a);
    else pass_cnt++;
    up_dn_a = 1'b1;
    tick();
    total_cnt++;
    if (out_a !== 4'h5) $display("FAIL ud_flip: got %0h expected 5", out_a);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_a !== 4'h6) $display("FAIL ud_flip_next: got %0h expected 6", out_a);
    else pass_cnt++;
    up_dn_a = 1'b0;
    force dut_a.out_q = 4'hC;
    #1 release dut_a.out_q;
    tick();
    total_cnt++;
    if (out_a !== 4'h9) $display("FAIL ud_illegal: got %0h expected 9", out_a);
    else pass_cnt++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_count_wrap();
    test_reset_glitch();
    test_mid_reset();
    test_pow2();
    test_illegal_state();
`ifdef MOD_N_COUNTER_UPDOWN_EN
    test_updown();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
